// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : Load/store unit between EX/MEM and data memory. Converts a load
//            or store into a req/ack word access with byte enables, stalls
//            the pipeline until completion and right-aligns load data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           dmem_data,
  output logic                  access_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           dmem_data_q, dmem_data_d;
  logic                  fault_q, fault_d;
  logic [1:0]            off_q, off_d;   // byte offset kept for load alignment

  logic                  w_mem_op;
  logic                  w_f3_legal;
  logic                  w_fault;
  logic [3:0]            w_lane_be;
  logic [31:0]           w_lane_wdata;

  assign w_mem_op = valid_in & (is_load | is_store);

  // Decode access legality: bad funct3, conflicting opcode flags, unsigned stores, misalignment
  always_comb begin
    w_f3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
      default:                                w_f3_legal = 1'b0;
    endcase
    w_fault = w_mem_op & ((is_load & is_store)
                        | ~w_f3_legal
                        | (is_store & funct3[2])
                        | ((funct3[1:0] == 2'b01) & addr[0])
                        | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
  end

  // Store lane steering: replicate data across lanes, enable only the addressed bytes
  always_comb begin
    w_lane_be    = 4'b1111;
    w_lane_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_lane_be    = 4'b0001 << addr[1:0];
        w_lane_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_lane_be    = 4'b0011 << addr[1:0];
        w_lane_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_lane_be    = 4'b1111;
        w_lane_wdata = store_data;
      end
    endcase
  end

  // Next-state and registered-output logic; everything holds unless a transition updates it
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    dmem_data_d = dmem_data_q;
    off_d       = off_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_mem_op) begin
          if (w_fault) begin
            dmem_data_d = 32'h0;
            fault_d     = 1'b1;
            state_d     = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = is_store ? w_lane_be : 4'b1111;
            mem_wdata_d = is_store ? w_lane_wdata : 32'h0;
            off_d       = addr[1:0];
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          dmem_data_d = mem_we_q ? 32'h0 : (mem_rdata >> {off_q, 3'b000});
          state_d     = DONE;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; the op still visible on valid_in is not reissued
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      dmem_data_q <= 32'h0;
      fault_q     <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      dmem_data_q <= dmem_data_d;
      fault_q     <= fault_d;
      off_q       <= off_d;
    end
  end

  assign stall        = ((state_q == IDLE) & w_mem_op) | (state_q == WAIT);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign dmem_data    = dmem_data_q;
  assign access_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Directed self-checking bench for dmem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] dmem_data;
  logic        access_fault;

  int errors = 0;
  int checks = 0;

  // Observations collected by run_op
  int          r_stalls, r_reqcyc, r_faultcyc;
  logic [31:0] r_addr, r_wdata, r_dmem;
  logic [3:0]  r_be;
  logic        r_we, r_fault_done, r_req_done, r_timeout;
  logic [31:0] sext;

  dmem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dmem_data(dmem_data), .access_fault(access_fault)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    valid_in = v; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
  endtask

  // Called at a negedge with the op on the inputs. The memory acks in the
  // wait_cycles-th cycle of the request. Returns at the negedge after DONE.
  task automatic run_op(input int wait_cycles, input logic [31:0] rdata);
    int  wc;
    bit  seen, done;
    wc = 0; seen = 0; done = 0;
    r_stalls = 0; r_reqcyc = 0; r_faultcyc = 0;
    r_addr = 32'hx; r_wdata = 32'hx; r_be = 4'hx; r_we = 1'bx;
    r_dmem = 32'hx; r_fault_done = 1'bx; r_req_done = 1'bx;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (stall) begin r_stalls++; seen = 1; end
      if (mem_req) begin
        if (r_reqcyc == 0) begin
          r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be; r_we = mem_we;
        end
        r_reqcyc++;
      end
      if (access_fault) r_faultcyc++;
      if (seen && !stall) begin
        done = 1; r_dmem = dmem_data; r_fault_done = access_fault; r_req_done = mem_req;
      end else if (mem_req) begin
        if (wc == wait_cycles - 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
        wc++;
      end
      @(negedge clock);
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end
    r_timeout = !done;
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL reset_req_fields: got we=%b be=%h addr=%h wdata=%h expected all 0", mem_we, mem_be, mem_addr, mem_wdata); end
    checks++; if ({dmem_data, access_fault} !== 33'h0) begin errors++; $display("FAIL reset_data: got dmem=%h fault=%b expected 0", dmem_data, access_fault); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_lw_zero_wait();
    drive(1, 1, 0, 3'b010, 32'h104, 32'h0);
    run_op(1, 32'hDEAD_BEEF);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL lw_timeout: got %b expected 0", r_timeout); end
    checks++; if (r_stalls != 2) begin errors++; $display("FAIL lw_stalls: got %0d expected 2", r_stalls); end
    checks++; if (r_reqcyc != 1) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 1", r_reqcyc); end
    checks++; if (r_addr !== 32'h104) begin errors++; $display("FAIL lw_addr: got %h expected 00000104", r_addr); end
    checks++; if ({r_we, r_be, r_wdata} !== {1'b0, 4'hF, 32'h0}) begin errors++; $display("FAIL lw_fields: got we=%b be=%h wdata=%h expected 0 f 00000000", r_we, r_be, r_wdata); end
    checks++; if (r_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dmem: got %h expected deadbeef", r_dmem); end
    checks++; if ({r_fault_done, r_req_done} !== 2'b00) begin errors++; $display("FAIL lw_done_flags: got fault=%b req=%b expected 0 0", r_fault_done, r_req_done); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0); #1;
    checks++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL lw_after: got stall=%b req=%b expected 0 0", stall, mem_req); end
    checks++; if (dmem_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold: got %h expected deadbeef", dmem_data); end
    @(negedge clock);
  endtask

  task automatic test_lb_wait();
    drive(1, 1, 0, 3'b000, 32'h103, 32'h0);
    run_op(3, 32'h80FF_1234);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL lb_timeout: got %b expected 0", r_timeout); end
    checks++; if (r_stalls != 4) begin errors++; $display("FAIL lb_stalls: got %0d expected 4", r_stalls); end
    checks++; if (r_reqcyc != 3) begin errors++; $display("FAIL lb_req_cycles: got %0d expected 3", r_reqcyc); end
    checks++; if ({r_addr, r_be} !== {32'h100, 4'hF}) begin errors++; $display("FAIL lb_addr_be: got %h %h expected 00000100 f", r_addr, r_be); end
    checks++; if (r_dmem !== 32'h0000_0080) begin errors++; $display("FAIL lb_dmem: got %h expected 00000080", r_dmem); end
    sext = {{24{r_dmem[7]}}, r_dmem[7:0]};
    checks++; if (sext !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", sext); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_fault();
    drive(1, 1, 0, 3'b010, 32'h101, 32'h0);
    run_op(1, 32'h1111_1111);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL fault_timeout: got %b expected 0", r_timeout); end
    checks++; if (r_reqcyc != 0) begin errors++; $display("FAIL fault_req: got %0d expected 0", r_reqcyc); end
    checks++; if (r_stalls != 1) begin errors++; $display("FAIL fault_stalls: got %0d expected 1", r_stalls); end
    checks++; if ({r_fault_done, r_faultcyc} !== {1'b1, 32'd1}) begin errors++; $display("FAIL fault_pulse: got done=%b cycles=%0d expected 1 1", r_fault_done, r_faultcyc); end
    checks++; if (r_dmem !== 32'h0) begin errors++; $display("FAIL fault_dmem: got %h expected 00000000", r_dmem); end
    // Unsigned store variant is illegal
    drive(1, 0, 1, 3'b100, 32'h0, 32'hFF);
    run_op(1, 32'h0);
    checks++; if ({r_fault_done, r_reqcyc} !== {1'b1, 32'd0}) begin errors++; $display("FAIL sbu_fault: got fault=%b req=%0d expected 1 0", r_fault_done, r_reqcyc); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (access_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", access_fault); end
    @(negedge clock);
  endtask

  task automatic test_store_lanes();
    drive(1, 0, 1, 3'b001, 32'h202, 32'h1234_ABCD);
    run_op(1, 32'hFFFF_FFFF);
    checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL sh_timeout: got %b expected 0", r_timeout); end
    checks++; if ({r_we, r_be} !== {1'b1, 4'b1100}) begin errors++; $display("FAIL sh_we_be: got %b %b expected 1 1100", r_we, r_be); end
    checks++; if (r_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", r_wdata); end
    checks++; if (r_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h expected 00000200", r_addr); end
    checks++; if ({r_dmem, r_stalls} !== {32'h0, 32'd2}) begin errors++; $display("FAIL sh_dmem_stalls: got %h %0d expected 00000000 2", r_dmem, r_stalls); end
    drive(1, 0, 1, 3'b000, 32'h301, 32'h0000_005A);
    run_op(1, 32'h0);
    checks++; if ({r_be, r_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++; $display("FAIL sb_lanes: got be=%b wdata=%h expected 0010 5a5a5a5a", r_be, r_wdata); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 3'b000, 32'h104, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL alu_pass_%0d: got stall=%b req=%b expected 0 0", k, stall, mem_req); end
      @(negedge clock);
    end
    drive(1, 0, 1, 3'b010, 32'h208, 32'hCAFE_F00D);
    run_op(1, 32'h0);
    checks++; if ({r_stalls, r_reqcyc} !== {32'd2, 32'd1}) begin errors++; $display("FAIL sw_cycles: got stalls=%0d req=%0d expected 2 1", r_stalls, r_reqcyc); end
    checks++; if ({r_we, r_be, r_wdata} !== {1'b1, 4'hF, 32'hCAFE_F00D}) begin errors++; $display("FAIL sw_fields: got we=%b be=%h wdata=%h expected 1 f cafef00d", r_we, r_be, r_wdata); end
    drive(1, 1, 0, 3'b010, 32'h208, 32'h0);
    run_op(1, 32'h1122_3344);
    checks++; if ({r_stalls, r_reqcyc} !== {32'd2, 32'd1}) begin errors++; $display("FAIL b2b_lw_cycles: got stalls=%0d req=%0d expected 2 1", r_stalls, r_reqcyc); end
    checks++; if (r_dmem !== 32'h1122_3344) begin errors++; $display("FAIL b2b_lw_dmem: got %h expected 11223344", r_dmem); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 3'b010, 32'h104, 32'h0);
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_up: got %b expected 1", mem_req); end
    #1 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_drop: got %b expected 0", mem_req); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clock); reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock); mem_ack = 1'b0; #1;
    checks++; if ({dmem_data, mem_req, stall} !== {32'h0, 2'b00}) begin errors++; $display("FAIL rst_stray_ack: got dmem=%h req=%b stall=%b expected 00000000 0 0", dmem_data, mem_req, stall); end
    @(negedge clock);
    drive(1, 1, 0, 3'b101, 32'h10E, 32'h0);
    run_op(1, 32'hBEEF_0BAD);
    checks++; if ({r_stalls, r_reqcyc} !== {32'd2, 32'd1}) begin errors++; $display("FAIL rst_resume_cycles: got stalls=%0d req=%0d expected 2 1", r_stalls, r_reqcyc); end
    checks++; if (r_dmem !== 32'h0000_BEEF) begin errors++; $display("FAIL rst_resume_lhu: got %h expected 0000beef", r_dmem); end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_lb_wait();
    test_fault();
    test_store_lanes();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store unit between the EX/MEM pipeline register and the data memory; produces the `dmemData` word consumed by the MEM stage. It turns a load or store in EX/MEM into a req/ack transaction on a word-addressed memory port with byte enables. It stalls the pipeline until the access completes. Load data is returned right-aligned, so MEM's LB/LH sign extension on bits [7:0]/[15:0] is correct for any byte offset.

## Interface
- ADDR_WIDTH, 32, width of byte address and `mem_addr`
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- valid_in  in  1  EX/MEM holds a live instruction
- is_load  in  1  EX/MEM opcode is LOAD
- is_store  in  1  EX/MEM opcode is STORE
- funct3  in  3  EX/MEM funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  ADDR_WIDTH  byte address (EX/MEM alu_result)
- store_data  in  32  rs2 value from EX/MEM
- stall  out  1  freeze IF..EX/MEM registers and hold EX/MEM contents
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word address: addr with [1:0] forced to 00
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, one-cycle pulse, only while mem_req=1
- mem_rdata  in  32  read word, valid in the `mem_ack` cycle
- dmem_data  out  32  right-aligned load result to MEM
- access_fault  out  1  misaligned or illegal access, one-cycle pulse

## Operation
- FSM states: IDLE, WAIT, DONE. Reset values: state IDLE, all outputs 0.
- mem_op = valid_in & (is_load | is_store).
- fault = mem_op & one of the following:
  - is_load & is_store
  - funct3 is not in {000, 001, 010, 100, 101}
  - funct3 is a store variant 100 or 101
  - halfword access with addr[0]=1
  - word access with addr[1:0]≠00
- IDLE, no mem_op: no action. `stall`=0. Non-memory ops pass with zero penalty.
- IDLE, mem_op & !fault: register the request into `mem_addr`/`mem_we`/`mem_be`/`mem_wdata`, set `mem_req`=1, go to WAIT.
- IDLE, fault: clear `dmem_data`, set `access_fault`, go to DONE. No memory request is issued.
- WAIT: hold `mem_req` and all request fields stable until `mem_ack`. On `mem_ack`:
  - `mem_req`=0.
  - load: `dmem_data` = `mem_rdata` >> (8*addr[1:0]), shifted as a 32-bit logical right shift.
  - store: `dmem_data` = 0.
  - Go to DONE.
- DONE: `stall`=0 and the pipeline advances at the end of this cycle. Always return to IDLE. Never reissue, even though `valid_in` still shows the same op.
- `stall` is combinational: (IDLE & mem_op) | WAIT.
- Store lanes:
  - SB: `mem_wdata`={4{store_data[7:0]}}, `mem_be`=0001<<addr[1:0].
  - SH: `mem_wdata`={2{store_data[15:0]}}, `mem_be`=0011<<addr[1:0].
  - SW: `mem_wdata`=store_data, `mem_be`=1111.
- Loads: `mem_be`=1111, `mem_we`=0, `mem_wdata`=0.
- `dmem_data` holds its value outside the WAIT→DONE and fault updates.
- Reset mid-transaction: state goes to IDLE and `mem_req` drops immediately, asynchronously. The outstanding access is abandoned and a late `mem_ack` is ignored.

## Timing
- Zero-wait memory (ack in first WAIT cycle): every memory op stalls 2 cycles and occupies EX/MEM for 3 cycles.
- Each extra memory wait cycle adds one stall cycle. There is no timeout.
- Fault: stall 1 cycle. `access_fault` is high only in the DONE cycle.
- `mem_req` rises one edge after the op enters EX/MEM. It falls on the edge that samples `mem_ack`.
- `dmem_data` is valid from the start of DONE, the same cycle MEM samples it.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE. No overlap.

## Test plan
- LW addr 0x104, memory returns 0xDEADBEEF with zero wait:
  - `mem_addr`=0x104, `mem_be`=1111, `stall` high for 2 cycles.
  - `dmem_data`=0xDEADBEEF in DONE.
- LB addr 0x103, `mem_rdata`=0x80FF_1234, 3 wait cycles:
  - 4 stall cycles, `dmem_data`=0x0000_0080.
  - MEM then writes back 0xFFFF_FF80.
- SH addr 0x202, store_data 0x1234_ABCD: `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_addr`=0x200.
- LW addr 0x101: no `mem_req`, 1 stall cycle, `access_fault` pulse, `dmem_data`=0.
- ALU op with `valid_in`=1 and `is_load`=`is_store`=0: `stall`=0 and no `mem_req`. Then SW and LW back-to-back: two separate 3-cycle transactions with no reissue.
- Assert `reset`=0 in WAIT with `mem_req`=1: `mem_req` falls without a clock edge. After release the FSM is in IDLE. A stray `mem_ack` leaves `dmem_data` unchanged.
